// File: rtl/sisc_pkg.sv
// sisc_pkg: shared fetch-stage types and constants
package sisc_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] SISC_NOP = 32'h0;
  localparam logic BR_REL = 1'b0;
  localparam logic BR_ABS = 1'b1;
  typedef enum logic {IDLE, WAIT} fetch_state_t;
endpackage

// File: rtl/sisc_pc.sv
// sisc_pc: program counter with pending-branch register and next-pc mux
module sisc_pc import sisc_pkg::*; #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            idle,
  input  logic            ack,
  input  logic            pc_write,
  input  logic            br_sel,
  input  logic [15:0]     br_imm,
  output logic [PC_W-1:0] pc
);
  localparam logic [PC_W-1:0] ONE = 1;
  logic [PC_W-1:0] target, pend;
  logic pend_valid, br_wait;
  assign target = br_sel == BR_ABS ? PC_W'(br_imm) : pc + PC_W'($signed(br_imm));
  assign br_wait = pc_write && !idle;
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc <= RESET_PC;
      pend <= '0;
      pend_valid <= 1'b0;
    end else begin
      pc <= ack ? (pc_write ? target : pend_valid ? pend : pc + ONE) : (idle && pc_write) ? target : pc;
      pend <= br_wait ? target : pend;
      pend_valid <= !ack && (pend_valid || br_wait);
    end
  end
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction-fetch stage holding PC and IR with memory req/ack handshake
module sisc_fetch import sisc_pkg::*; #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               fetch_req,
  input  logic               pc_write,
  input  logic               br_sel,
  input  logic [15:0]        br_imm,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_rd,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               im_ack,
  output logic [INSTR_W-1:0] instruction,
  output logic               ir_valid,
  output logic               busy,
  output logic [PC_W-1:0]    pc
);
  fetch_state_t state;
  logic idle, ack;
  assign idle = state == IDLE;
  assign ack = !idle && im_ack;
  assign im_rd = !idle;
  assign busy = !idle;
  assign im_addr = pc;
  sisc_pc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_f(rst_f), .idle(idle), .ack(ack), .pc_write(pc_write),
    .br_sel(br_sel), .br_imm(br_imm), .pc(pc)
  );
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state <= IDLE;
      instruction <= SISC_NOP;
      ir_valid <= 1'b0;
    end else begin
      state <= idle ? (fetch_req ? WAIT : IDLE) : (im_ack ? IDLE : WAIT);
      instruction <= ack ? im_data : instruction;
      ir_valid <= ack;
    end
  end
endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction-fetch stage directly upstream of the SISC datapath.
- Holds the program counter (PC) and the instruction register (IR), and runs a req/ack handshake with instruction memory.
- Applies branch updates requested by ctrl.
- Its `instruction` output drives the datapath/ctrl `instruction` input.

Parameters:
- PC_W, 16, program-counter and instruction-memory word-address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_f  in  1  reset, synchronous, active-low
- fetch_req  in  1  ctrl request to fetch the next instruction; sampled only in IDLE
- pc_write  in  1  ctrl branch-taken strobe, one cycle
- br_sel  in  1  branch mode: 0 = relative, 1 = absolute
- br_imm  in  16  branch offset or target (IR[15:0])
- im_addr  out  PC_W  instruction-memory word address
- im_rd  out  1  memory read request
- im_data  in  32  memory read data, valid with im_ack
- im_ack  in  1  memory data valid, one cycle
- instruction  out  32  current IR, feeds datapath and ctrl
- ir_valid  out  1  one-cycle pulse: new IR is valid
- busy  out  1  fetch in progress
- pc  out  PC_W  current PC

Behaviour:
- Reset (rst_f=0 at an edge), values after that edge:
  - state=IDLE, pc=RESET_PC, instruction=32'h0 (NOP)
  - ir_valid=0, im_rd=0, busy=0, pending branch cleared
- FSM states are IDLE and WAIT.
- IDLE:
  - im_rd=0, busy=0.
  - fetch_req=1 → WAIT.
- WAIT:
  - im_rd=1, busy=1, im_addr=pc (held stable).
  - im_ack=1 at an edge → IR<=im_data, then pc update (below), ir_valid=1 for the next cycle only, → IDLE.
  - No timeout: WAIT persists until im_ack.
- PC update on ack: pc <= pending branch target if a branch is pending, else pc+1.
- Branch target computation, evaluated with pc at the pc_write cycle:
  - relative: pc + sign_extend(br_imm)
  - absolute: zero_extend(br_imm)
  - Result truncated to PC_W bits, so it wraps modulo 2^PC_W.
- pc_write in IDLE: pc <= target at that edge.
- pc_write and fetch_req together in IDLE: branch applies first; the fetch in WAIT uses the new pc.
- pc_write in WAIT:
  - Target is latched as pending and applied on the ack edge instead of the increment.
  - im_addr is unchanged.
  - A second pc_write in the same WAIT overwrites the pending target.
- pc_write on the same edge as im_ack: the target replaces the increment.
- fetch_req in WAIT is ignored; it is not queued.
- im_ack in IDLE is ignored; IR and pc are unchanged.
- Wrap-around: pc = 2^PC_W−1 increments to 0.
- Latency: fetch_req sampled at edge N → im_rd high in cycle N+1.
  - Zero-wait memory (ack in that cycle) → ir_valid high in cycle N+2.
  - Minimum fetch-to-fetch period is 2 cycles.
- Reset mid-fetch: im_rd drops after the reset edge; a later stray ack is ignored.
- The instruction output changes only on ack edges and reset.

Decomposition:
- Package sisc_pkg:
  - fetch state enum (IDLE, WAIT)
  - SISC_NOP = 32'h0
  - INSTR_W = 32
  - BR_REL = 1'b0, BR_ABS = 1'b1
- Sub-module sisc_pc:
  - PC register, pending-branch register, next-pc mux (increment / relative / absolute)
  - Controlled by the FSM's ack and pc_write qualifiers.

Test Plan:
- Reset, then fetch_req pulse; memory returns 32'h1001_0005 with zero wait:
  - im_addr=0 while im_rd=1
  - instruction=32'h10010005 and ir_valid pulse two cycles after fetch_req
  - pc=1
- Memory acks 3 cycles late:
  - im_rd held 3 cycles with im_addr constant
  - fetch_req pulses during WAIT are ignored
  - exactly one ir_valid pulse
- pc=16'h0010, pc_write with br_sel=0, br_imm=16'hFFFC in IDLE → pc=16'h000C; with br_imm=16'h0003 → pc=16'h0013.
- pc_write with br_sel=1, br_imm=16'h0040 during WAIT at pc=5:
  - im_addr stays 5
  - on ack, pc=16'h0040 (not 6)
- pc=16'hFFFF, fetch completes → pc=16'h0000.
- rst_f=0 during WAIT:
  - next cycle im_rd=0, pc=RESET_PC, instruction=0
  - a subsequent stray im_ack changes nothing
